// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_ctrl_pkg
// Description : Shared sizes and FSM encoding for the memory port initiators.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_ctrl_pkg;

    localparam int NUM_PORTS = 4;
    localparam int ADDR_W    = 7;
    localparam int DATA_W    = 8;
    localparam int SEL_W     = 2;
    localparam int ST_W      = 3;

    typedef enum logic [ST_W-1:0] {
        IDLE       = 3'd0,
        WAIT_GRANT = 3'd1,
        ACCESS     = 3'd2,
        WAIT_DATA  = 3'd3,
        RESP       = 3'd4
    } state_e;

endpackage
`default_nettype wire

// File: rtl/mem_grant_timer.sv
`default_nettype none
// ============================================================================
// Module      : mem_grant_timer
// Description : Loadable up-counter with a terminal-count flag.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_grant_timer
    import mem_ctrl_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             inc_i,
    input  logic [CNT_W-1:0] term_val_i,
    output logic             term_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (inc_i) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign term_o = (count_q == term_val_i);

endmodule
`default_nettype wire

// File: rtl/mem_port_initiator.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_initiator
// Description : Client-side engine issuing single accesses on one mux port.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_initiator
    import mem_ctrl_pkg::*;
#(
    parameter int PORT_ID      = 0,
    parameter int ADDR_W       = mem_ctrl_pkg::ADDR_W,
    parameter int DATA_W       = mem_ctrl_pkg::DATA_W,
    parameter int READ_LATENCY = 1,
    parameter int TIMEOUT      = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [DATA_W-1:0] rsp_rdata,
    input  logic [SEL_W-1:0]  state,
    input  logic              en,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int c_cnt_max = (TIMEOUT > 4) ? TIMEOUT : 4;
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);

    localparam logic [SEL_W-1:0]   c_port_sel = SEL_W'(PORT_ID);
    localparam logic [c_cnt_w-1:0] c_tmo_term = c_cnt_w'(TIMEOUT - 1);
    localparam logic [c_cnt_w-1:0] c_lat_term = c_cnt_w'(READ_LATENCY - 1);

    generate
        if (PORT_ID < 0 || PORT_ID >= NUM_PORTS) begin : g_bad_port_id
            $error("mem_port_initiator: PORT_ID %0d outside 0..%0d", PORT_ID, NUM_PORTS - 1);
        end
        if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
            $error("mem_port_initiator: READ_LATENCY %0d outside 1..4", READ_LATENCY);
        end
        if (TIMEOUT < 1) begin : g_bad_timeout
            $error("mem_port_initiator: TIMEOUT %0d must be at least 1", TIMEOUT);
        end
    endgenerate

    state_e              state_q,       state_d;
    logic                req_ready_q,   req_ready_d;
    logic                rsp_valid_q,   rsp_valid_d;
    logic                rsp_err_q,     rsp_err_d;
    logic [DATA_W-1:0]   rsp_rdata_q,   rsp_rdata_d;
    logic                mem_read_q,    mem_read_d;
    logic                mem_write_q,   mem_write_d;
    logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
    logic [DATA_W-1:0]   mem_wdata_q,   mem_wdata_d;
    logic                write_q,       write_d;
    logic                err_q,         err_d;
    logic [DATA_W-1:0]   data_q,        data_d;

    logic                w_grant;
    logic                w_accept;
    logic                w_tmr_load;
    logic                w_tmr_inc;
    logic                w_tmr_term;
    logic [c_cnt_w-1:0]  w_term_val;

    assign w_grant  = en && (state == c_port_sel);
    assign w_accept = req_valid && req_ready_q;

    // One counter serves both phases: grant wait before the access, data wait after.
    assign w_term_val = (state_q == WAIT_DATA) ? c_lat_term : c_tmo_term;

    mem_grant_timer #(
        .CNT_W      (c_cnt_w)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (w_tmr_load),
        .load_val_i ({c_cnt_w{1'b0}}),
        .inc_i      (w_tmr_inc),
        .term_val_i (w_term_val),
        .term_o     (w_tmr_term)
    );

    always_comb begin
        state_d       = state_q;
        req_ready_d   = 1'b0;
        rsp_valid_d   = 1'b0;
        rsp_err_d     = 1'b0;
        rsp_rdata_d   = '0;
        mem_read_d    = 1'b0;
        mem_write_d   = 1'b0;
        mem_address_d = mem_address_q;
        mem_wdata_d   = mem_wdata_q;
        write_d       = write_q;
        err_d         = err_q;
        data_d        = data_q;
        w_tmr_load    = 1'b0;
        w_tmr_inc     = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                if (w_accept) begin
                    req_ready_d   = 1'b0;
                    write_d       = req_write;
                    mem_address_d = req_addr;
                    mem_wdata_d   = req_wdata;
                    err_d         = 1'b0;
                    data_d        = '0;
                    w_tmr_load    = 1'b1;
                    state_d       = WAIT_GRANT;
                end
            end

            WAIT_GRANT: begin
                // Grant is checked first so it beats a timeout on the same edge.
                if (w_grant) begin
                    mem_read_d  = !write_q;
                    mem_write_d = write_q;
                    state_d     = ACCESS;
                end else if (w_tmr_term) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    w_tmr_inc = 1'b1;
                end
            end

            ACCESS: begin
                if (!w_grant) begin
                    state_d = WAIT_GRANT;
                end else if (write_q) begin
                    state_d = RESP;
                end else begin
                    w_tmr_load = 1'b1;
                    state_d    = WAIT_DATA;
                end
            end

            WAIT_DATA: begin
                if (w_tmr_term) begin
                    data_d  = mem_rdata;
                    state_d = RESP;
                end else begin
                    w_tmr_inc = 1'b1;
                end
            end

            RESP: begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = err_q;
                rsp_rdata_d = data_q;
                state_d     = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            req_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_err_q     <= 1'b0;
            rsp_rdata_q   <= '0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_address_q <= '0;
            mem_wdata_q   <= '0;
            write_q       <= 1'b0;
            err_q         <= 1'b0;
            data_q        <= '0;
        end else begin
            state_q       <= state_d;
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_err_q     <= rsp_err_d;
            rsp_rdata_q   <= rsp_rdata_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            mem_address_q <= mem_address_d;
            mem_wdata_q   <= mem_wdata_d;
            write_q       <= write_d;
            err_q         <= err_d;
            data_q        <= data_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign mem_address = mem_address_q;
    assign mem_wdata   = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_initiator.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_initiator
// Description : Scoreboard bench for two mem_port_initiator configurations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_initiator;

    typedef struct {
        logic       err;
        logic [7:0] rd;
        int         cyc;
    } exp_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_write = 1'b0;
    logic [6:0] req_addr  = '0;
    logic [7:0] req_wdata = '0;

    logic       req_valid_a = 1'b0, req_ready_a, rsp_valid_a, rsp_err_a;
    logic [7:0] rsp_rdata_a;
    logic [1:0] state_a = 2'd1;
    logic       en_a = 1'b1, mem_read_a, mem_write_a;
    logic [6:0] mem_address_a;
    logic [7:0] mem_wdata_a, mem_rdata_a;

    logic       req_valid_b = 1'b0, req_ready_b, rsp_valid_b, rsp_err_b;
    logic [7:0] rsp_rdata_b;
    logic [1:0] state_b = 2'd0;
    logic       en_b = 1'b1, mem_read_b, mem_write_b;
    logic [6:0] mem_address_b;
    logic [7:0] mem_wdata_b, mem_rdata_b;

    int checks = 0, failures = 0, cyc = 0;
    int n_wr_a = 0, n_rd_a = 0, n_rsp_a = 0, n_wr_b = 0, n_rd_b = 0, n_rsp_b = 0;
    logic [6:0] last_addr_a = '0;
    logic [7:0] last_wd_a = '0;
    exp_t q_a[$], q_b[$];

    logic [7:0] mem_a [0:127];
    logic [7:0] mem_b [0:127];
    logic [7:0] ref_a [0:127];
    logic [7:0] ref_b [0:127];
    logic [7:0] p1_b, p2_b;

    mem_port_initiator #(.PORT_ID(1), .ADDR_W(7), .DATA_W(8), .READ_LATENCY(1), .TIMEOUT(64)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid_a), .req_ready(req_ready_a),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_a), .rsp_err(rsp_err_a), .rsp_rdata(rsp_rdata_a),
        .state(state_a), .en(en_a), .mem_read(mem_read_a), .mem_write(mem_write_a),
        .mem_address(mem_address_a), .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a));

    mem_port_initiator #(.PORT_ID(2), .ADDR_W(7), .DATA_W(8), .READ_LATENCY(3), .TIMEOUT(8)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid_b), .req_ready(req_ready_b),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_b), .rsp_err(rsp_err_b), .rsp_rdata(rsp_rdata_b),
        .state(state_b), .en(en_b), .mem_read(mem_read_b), .mem_write(mem_write_b),
        .mem_address(mem_address_b), .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory models: read data is present for exactly one cycle, READ_LATENCY after the strobe edge.
    always @(posedge clk) begin
        if (mem_write_a) mem_a[mem_address_a] <= mem_wdata_a;
        mem_rdata_a <= mem_read_a ? mem_a[mem_address_a] : 8'h00;
        if (mem_write_b) mem_b[mem_address_b] <= mem_wdata_b;
        p1_b        <= mem_read_b ? mem_b[mem_address_b] : 8'h00;
        p2_b        <= p1_b;
        mem_rdata_b <= p2_b;
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (mem_write_a) begin n_wr_a++; last_addr_a = mem_address_a; last_wd_a = mem_wdata_a; end
            if (mem_read_a) begin n_rd_a++; last_addr_a = mem_address_a; end
            if (mem_write_b) n_wr_b++;
            if (mem_read_b) n_rd_b++;
            if (rsp_valid_a) begin
                n_rsp_a++; checks++;
                if (q_a.size() == 0) begin
                    failures++;
                    $display("FAIL rsp_a_unexpected: got rsp err=%0b rdata=%02h at cycle %0d, required no response", rsp_err_a, rsp_rdata_a, cyc);
                end else begin
                    e = q_a.pop_front();
                    if (rsp_err_a !== e.err || rsp_rdata_a !== e.rd || cyc !== e.cyc) begin
                        failures++;
                        $display("FAIL rsp_a: got err=%0b rdata=%02h cycle=%0d, required err=%0b rdata=%02h cycle=%0d", rsp_err_a, rsp_rdata_a, cyc, e.err, e.rd, e.cyc);
                    end
                end
            end
            if (rsp_valid_b) begin
                n_rsp_b++; checks++;
                if (q_b.size() == 0) begin
                    failures++;
                    $display("FAIL rsp_b_unexpected: got rsp err=%0b rdata=%02h at cycle %0d, required no response", rsp_err_b, rsp_rdata_b, cyc);
                end else begin
                    e = q_b.pop_front();
                    if (rsp_err_b !== e.err || rsp_rdata_b !== e.rd || cyc !== e.cyc) begin
                        failures++;
                        $display("FAIL rsp_b: got err=%0b rdata=%02h cycle=%0d, required err=%0b rdata=%02h cycle=%0d", rsp_err_b, rsp_rdata_b, cyc, e.err, e.rd, e.cyc);
                    end
                end
            end
        end
    end

    // Called at a falling edge; returns on the falling edge after the accept edge.
    task automatic send(input bit b, input bit w, input logic [6:0] a, input logic [7:0] d,
                        input bit push, input bit exp_err, input logic [7:0] exp_rd, input int exp_lat);
        int   n;
        exp_t e;
        n = 0;
        while (((b ? req_ready_b : req_ready_a) !== 1'b1) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++; failures++;
            $display("FAIL req_ready_%s: stayed low for 50 cycles, required 1", b ? "b" : "a");
        end
        req_write = w; req_addr = a; req_wdata = d;
        if (b) req_valid_b = 1'b1; else req_valid_a = 1'b1;
        @(negedge clk);
        req_valid_a = 1'b0; req_valid_b = 1'b0;
        if (w) begin
            if (b) ref_b[a] = d; else ref_a[a] = d;
        end
        if (push) begin
            e.err = exp_err; e.rd = exp_rd; e.cyc = cyc + exp_lat;
            if (b) q_b.push_back(e); else q_a.push_back(e);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++; failures++;
            $display("FAIL drain: %0d/%0d responses outstanding after 200 cycles, required 0", q_a.size(), q_b.size());
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({req_ready_a, rsp_valid_a, rsp_err_a, rsp_rdata_a, mem_read_a, mem_write_a, mem_address_a, mem_wdata_a} !== 28'd0) begin
            failures++; $display("FAIL reset_outputs_a: got nonzero outputs, required all 0");
        end
        checks++;
        if ({req_ready_b, rsp_valid_b, rsp_err_b, rsp_rdata_b, mem_read_b, mem_write_b, mem_address_b, mem_wdata_b} !== 28'd0) begin
            failures++; $display("FAIL reset_outputs_b: got nonzero outputs, required all 0");
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (req_ready_a !== 1'b0) begin failures++; $display("FAIL ready_before_edge: got %0b, required 0", req_ready_a); end
        @(negedge clk);
        checks++;
        if (req_ready_a !== 1'b1 || req_ready_b !== 1'b1) begin
            failures++; $display("FAIL ready_after_edge: got a=%0b b=%0b, required 1 1", req_ready_a, req_ready_b);
        end
    endtask

    task automatic test_write();
        state_a = 2'd1; en_a = 1'b1; n_wr_a = 0; n_rd_a = 0; n_rsp_a = 0;
        send(0, 1, 7'd10, 8'd10, 1, 0, 8'h00, 3);
        drain();
        checks++;
        if (n_wr_a !== 1 || n_rd_a !== 0 || n_rsp_a !== 1) begin
            failures++; $display("FAIL write_strobes: got wr=%0d rd=%0d rsp=%0d, required 1 0 1", n_wr_a, n_rd_a, n_rsp_a);
        end
        checks++;
        if (last_addr_a !== 7'd10 || last_wd_a !== 8'd10) begin
            failures++; $display("FAIL write_bus: got addr=%0d wdata=%0d, required 10 10", last_addr_a, last_wd_a);
        end
    endtask

    task automatic test_read();
        n_wr_a = 0; n_rd_a = 0;
        send(0, 0, 7'd10, 8'h00, 1, 0, ref_a[10], 4);
        drain();
        checks++;
        if (n_rd_a !== 1 || n_wr_a !== 0) begin
            failures++; $display("FAIL read_strobes: got rd=%0d wr=%0d, required 1 0", n_rd_a, n_wr_a);
        end
        checks++;
        if (mem_address_a !== 7'd10) begin
            failures++; $display("FAIL addr_hold_idle: got %0d, required 10", mem_address_a);
        end
    endtask

    task automatic test_wait_grant();
        int bad;
        bad = 0;
        state_a = 2'd0; n_wr_a = 0;
        send(0, 1, 7'd33, 8'h5A, 1, 0, 8'h00, 23);
        checks++;
        if (mem_address_a !== 7'd33 || mem_wdata_a !== 8'h5A) begin
            failures++; $display("FAIL wait_bus: got addr=%0d wdata=%02h, required 33 5a", mem_address_a, mem_wdata_a);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_read_a !== 1'b0 || mem_write_a !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL wait_no_strobe: got %0d strobe cycles, required 0", bad); end
        state_a = 2'd1;
        @(negedge clk);
        checks++;
        if (mem_write_a !== 1'b1) begin failures++; $display("FAIL wait_access: got mem_write=%0b, required 1", mem_write_a); end
        drain();
        checks++;
        if (n_wr_a !== 1) begin failures++; $display("FAIL wait_strobes: got %0d writes, required 1", n_wr_a); end
    endtask

    task automatic test_grant_drop();
        n_rd_a = 0; n_rsp_a = 0;
        send(0, 0, 7'd10, 8'h00, 1, 0, ref_a[10], 6);
        @(negedge clk);
        checks++;
        if (mem_read_a !== 1'b1) begin failures++; $display("FAIL drop_first_strobe: got %0b, required 1", mem_read_a); end
        en_a = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_read_a !== 1'b0) begin failures++; $display("FAIL drop_strobe_low: got %0b, required 0", mem_read_a); end
        en_a = 1'b1;
        drain();
        checks++;
        if (n_rd_a !== 2 || n_rsp_a !== 1) begin
            failures++; $display("FAIL drop_retry: got rd=%0d rsp=%0d, required 2 1", n_rd_a, n_rsp_a);
        end
    endtask

    task automatic test_back_to_back();
        n_wr_a = 0; n_rd_a = 0;
        send(0, 1, 7'd5, 8'h33, 1, 0, 8'h00, 3);
        send(0, 1, 7'd6, 8'hC4, 1, 0, 8'h00, 3);
        send(0, 0, 7'd5, 8'h00, 1, 0, ref_a[5], 4);
        send(0, 0, 7'd6, 8'h00, 1, 0, ref_a[6], 4);
        drain();
        checks++;
        if (n_wr_a !== 2 || n_rd_a !== 2) begin
            failures++; $display("FAIL b2b_strobes: got wr=%0d rd=%0d, required 2 2", n_wr_a, n_rd_a);
        end
    endtask

    task automatic test_timeout();
        state_b = 2'd0; en_b = 1'b1; n_wr_b = 0; n_rd_b = 0; n_rsp_b = 0;
        send(1, 0, 7'd3, 8'h00, 1, 1, 8'h00, 9);
        drain();
        checks++;
        if (n_wr_b !== 0 || n_rd_b !== 0 || n_rsp_b !== 1) begin
            failures++; $display("FAIL timeout_strobes: got wr=%0d rd=%0d rsp=%0d, required 0 0 1", n_wr_b, n_rd_b, n_rsp_b);
        end
    endtask

    task automatic test_timeout_race();
        n_wr_b = 0;
        send(1, 1, 7'd20, 8'hA7, 1, 0, 8'h00, 10);
        repeat (7) @(negedge clk);
        state_b = 2'd2;
        drain();
        checks++;
        if (n_wr_b !== 1) begin failures++; $display("FAIL race_grant_wins: got %0d writes, required 1", n_wr_b); end
        n_rd_b = 0;
        send(1, 0, 7'd20, 8'h00, 1, 0, ref_b[20], 6);
        drain();
        checks++;
        if (n_rd_b !== 1) begin failures++; $display("FAIL latency3_strobes: got %0d reads, required 1", n_rd_b); end
    endtask

    task automatic test_reset_midop();
        state_a = 2'd1; en_a = 1'b1; n_rsp_a = 0;
        send(0, 0, 7'd10, 8'h00, 0, 0, 8'h00, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({req_ready_a, rsp_valid_a, rsp_err_a, rsp_rdata_a, mem_read_a, mem_write_a, mem_address_a, mem_wdata_a} !== 28'd0) begin
            failures++; $display("FAIL midop_reset_outputs: got nonzero outputs, required all 0");
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (req_ready_a !== 1'b0) begin failures++; $display("FAIL midop_ready_early: got %0b, required 0", req_ready_a); end
        @(negedge clk);
        checks++;
        if (req_ready_a !== 1'b1) begin failures++; $display("FAIL midop_ready: got %0b, required 1", req_ready_a); end
        repeat (6) @(negedge clk);
        checks++;
        if (n_rsp_a !== 0) begin failures++; $display("FAIL midop_no_rsp: got %0d responses, required 0", n_rsp_a); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_write();
        test_read();
        test_wait_grant();
        test_grant_drop();
        test_back_to_back();
        test_timeout();
        test_timeout_race();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/mem_port_initiator.md
Name: mem_port_initiator

Overview:
- Initiator-side engine for one client port of the four-port memory controller multiplexer.
- Accepts single read or write requests from a client (CPU stage, loader or DMA) over a valid/ready handshake.
- Waits for the controller to grant this port through its state/en select, then drives the port's read, write, address and data lines for one access cycle.
- Captures the read data and returns a one-cycle response pulse; gives up with an error after a grant timeout.

Parameters:
- PORT_ID, 0, controller port served (0-3); compared against the state input
- ADDR_W, 7, address width
- DATA_W, 8, data width
- READ_LATENCY, 1, cycles from the access-cycle edge to valid mem_rdata (1-4)
- TIMEOUT, 64, maximum cycles spent waiting for grant before an error response

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  client request valid
- req_ready  out  1  engine can accept a request
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  request address
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle response pulse
- rsp_err  out  1  qualifies rsp_valid; 1 = grant timeout, access not performed
- rsp_rdata  out  DATA_W  read data, valid with rsp_valid
- state  in  2  controller's currently selected port
- en  in  1  controller enable
- mem_read  out  1  port read strobe
- mem_write  out  1  port write strobe
- mem_address  out  ADDR_W  port address
- mem_wdata  out  DATA_W  port input data
- mem_rdata  in  DATA_W  port output data

Behaviour:
- Reset (rst_n low, any time, including mid-operation):
  - All outputs 0; FSM goes to IDLE; counters cleared; any in-flight request is dropped with no response.
  - req_ready rises on the first clock edge after rst_n deasserts.
- All outputs are registered. grant = en && (state == PORT_ID).
- States and transitions:
  - IDLE: req_ready=1. On req_valid&&req_ready, latch write/addr/wdata, req_ready→0, go to WAIT_GRANT. Requests are never accepted outside IDLE.
  - WAIT_GRANT:
    - mem_address/mem_wdata hold the latched values; strobes 0.
    - On grant, go to ACCESS and assert mem_read or mem_write in the next cycle.
    - A wait counter increments every WAIT_GRANT cycle. When it reaches TIMEOUT with no grant, go to RESP with rsp_err=1.
  - ACCESS:
    - Exactly one strobe is high for exactly one cycle.
    - If grant is still true during this cycle, the access counts: writes go to RESP, reads go to WAIT_DATA.
    - If grant is lost (en low or state changed), drop the strobe, return to WAIT_GRANT, and keep the wait counter (no reset) so the timeout bounds total wait time.
  - WAIT_DATA: count READ_LATENCY cycles from the ACCESS edge, capture mem_rdata into rsp_rdata, go to RESP.
  - RESP:
    - rsp_valid=1 for one cycle; rsp_rdata=0 for writes and errors.
    - Next state is IDLE, with req_ready=1 in the following cycle.
- Latency, reads with grant already present when the request is accepted: accept edge → strobe next cycle → data after READ_LATENCY → rsp_valid. Total 3+READ_LATENCY cycles from the accept edge.
- Latency, writes: rsp_valid 3 cycles after the accept edge.
- mem_address and mem_wdata are stable from WAIT_GRANT through RESP; they are not cleared between requests, only by reset.
- Boundary conditions:
  - TIMEOUT reached on the same edge that grant appears: grant wins.
  - PORT_ID outside 0-3 is a configuration error; flag it with an elaboration assertion.

Decomposition:
- Shared package mem_ctrl_pkg holds:
  - NUM_PORTS=4, ADDR_W=7, DATA_W=8
  - the port-select width of 2
  - an FSM state enum {IDLE, WAIT_GRANT, ACCESS, WAIT_DATA, RESP}
- One sub-module, mem_grant_timer: a loadable up-counter with a terminal flag, used for both the grant timeout and the read-latency count.

Test Plan:
- PORT_ID=0, state held at 0, en=1. Write addr 10, data 10 → mem_write high 1 cycle with mem_address=10 and mem_wdata=10; rsp_valid 3 cycles after accept; rsp_err=0.
- PORT_ID=1, state=1. Read addr 10 with a model returning 10 after latency 1 → mem_read 1 cycle; rsp_rdata=10 at cycle 4 after accept.
- PORT_ID=2, state=0 for 20 cycles, then 2 → strobes stay 0 while waiting; access happens on the cycle after state becomes 2; rsp_err=0.
- en toggled low during ACCESS → strobe drops; FSM retries on the next grant; exactly one rsp_valid.
- TIMEOUT=8, grant never given → rsp_valid with rsp_err=1 and rsp_rdata=0 at wait cycle 8; no strobe is ever seen.
- rst_n pulsed low during WAIT_DATA → outputs go to 0 immediately; no rsp_valid; req_ready=1 one edge after release.
